// File: rtl/instr_fifo_pkg.sv
// Shared widths, burst limit and burst-size helper for the per-unit instruction queues.
// Pure declarations: no logic, no latency, no flow control.
package instr_fifo_pkg;

    localparam int DMA_INSTR_W   = 22;
    localparam int ARITH_INSTR_W = 1;
    localparam int CACHE_INSTR_W = 17;
    localparam int MAX_BURST     = 4;

    // we_count encodes burst size minus one.
    function automatic logic [2:0] burst_size(input logic [1:0] we_count);
        return {1'b0, we_count} + 3'd1;
    endfunction

endpackage

// File: rtl/instr_fifo_ram.sv
// Storage array: four write ports at consecutive wrapped addresses, one registered read port.
// Latency: write visible next cycle, read data one cycle after rd_en.
// Backpressure: none; the owner guarantees writes never hit live entries.
module instr_fifo_ram
    import instr_fifo_pkg::*;
#(
    parameter  int WIDTH = DMA_INSTR_W,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [MAX_BURST-1:0]            wr_en,
    input  logic [AW-1:0]                   wr_addr,
    input  logic [MAX_BURST-1:0][WIDTH-1:0] wr_dat,
    input  logic                            rd_en,
    input  logic [AW-1:0]                   rd_addr,
    output logic [WIDTH-1:0]                rd_dat
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Port k lands at wr_addr+k; AW-bit addition wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        for (int k = 0; k < MAX_BURST; k++) begin
            if (wr_en[k]) begin
                mem[wr_addr + AW'(k)] <= wr_dat[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_dat <= '0;
        end else if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/instr_fifo.sv
// Instruction FIFO: 1-4 atomic pushes per cycle, one registered pop per cycle; INSTR_FIFO_ERR_EN adds sticky overflow/underflow.
// Latency: pop data one cycle after re; pushes become poppable the cycle after acceptance.
// Backpressure: bursts that do not fit are dropped whole; full_soon/empty_soon give 4-entry early warning.
module instr_fifo
    import instr_fifo_pkg::*;
#(
    parameter  int WIDTH = DMA_INSTR_W,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             re,
    input  logic             we,
    input  logic [1:0]       we_count,
    input  logic [WIDTH-1:0] dat_w_1,
    input  logic [WIDTH-1:0] dat_w_2,
    input  logic [WIDTH-1:0] dat_w_3,
    input  logic [WIDTH-1:0] dat_w_4,
    output logic [WIDTH-1:0] dat_r,
    output logic [CW-1:0]    count,
    output logic             full_soon,
    output logic             empty_soon,
    output logic             empty
`ifdef INSTR_FIFO_ERR_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);

    logic [AW-1:0]                   rd_ptr;
    logic [AW-1:0]                   wr_ptr;
    logic [CW-1:0]                   count_q;
    logic [CW-1:0]                   free;
    logic [2:0]                      burst_n;
    logic                            push_ok;
    logic                            pop_ok;
    logic [MAX_BURST-1:0]            wr_en;
    logic [MAX_BURST-1:0][WIDTH-1:0] wr_dat;

    assign burst_n = burst_size(we_count);
    assign free    = CW'(DEPTH) - count_q;

    // Acceptance uses occupancy before this cycle's pop, so a full FIFO rejects even with a pop pending.
    assign push_ok = we && !reset && (CW'(burst_n) <= free);
    assign pop_ok  = re && !reset && (count_q != '0);

    assign wr_dat = {dat_w_4, dat_w_3, dat_w_2, dat_w_1};

    always_comb begin
        wr_en = '0;
        for (int k = 0; k < MAX_BURST; k++) begin
            wr_en[k] = push_ok && (3'(k) < burst_n);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(burst_n);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_q + (push_ok ? CW'(burst_n) : '0) - (pop_ok ? CW'(1) : '0);
        end
    end

    instr_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_dat  (wr_dat),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr),
        .rd_dat  (dat_r)
    );

    assign count      = count_q;
    assign empty      = (count_q == '0);
    assign empty_soon = (count_q <= CW'(MAX_BURST));
    assign full_soon  = (free < CW'(MAX_BURST));

`ifdef INSTR_FIFO_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (we && !push_ok) begin
                overflow <= 1'b1;
            end
            if (re && (count_q == '0)) begin
                underflow <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(we && !push_ok))
        else $error("instr_fifo: push burst dropped");
    a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(re && (count_q == '0)))
        else $error("instr_fifo: pop from empty");
`endif
`endif

endmodule
